// File: rtl/glm_domain_pipe.sv
// glm_domain_pipe: pipelined GLM cubic domain function for the first-order
// masked PRINCE S-box, NIBBLES lanes wide.
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   input handshake; x (1b/lane), y (3b/lane), r (4b/lane)
//   out_valid/out_ready output handshake; s, t (4b/lane)
// Stage 1 registers the nonlinear monomials, so AND-layer glitches never reach
// the XOR compression. With PIPE=2 the compressed s/t are registered again.
// With PIPE=1 they are driven combinationally from stage 1.

// One lane: monomial register plus XOR compression and optional refresh.
module glm_domain_lane #(
  parameter int REFRESH_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ld,
  input  logic       i_x,
  input  logic [2:0] i_y,
  input  logic [3:0] i_r,
  output logic [3:0] o_s,
  output logic [3:0] o_t
);
  logic [9:0] w_mono, r_mono;
  logic       r_x;
  logic [2:0] r_y;
  logic [3:0] r_rnd, w_rm;
  logic       w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_i, w_j;

  // {j,i,h,g,f,e,d,c,b,a}
  assign w_mono = {i_y[0] & i_y[1] & i_y[2],
                   i_x & i_y[1] & i_y[2],
                   i_x & i_y[0] & i_y[2],
                   i_x & i_y[0] & i_y[1],
                   i_y[1] & i_y[2],
                   i_y[0] & i_y[2],
                   i_y[0] & i_y[1],
                   i_x & i_y[2],
                   i_x & i_y[1],
                   i_x & i_y[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mono <= '0;
      r_x    <= 1'b0;
      r_y    <= '0;
      r_rnd  <= '0;
    end else if (i_ld) begin
      r_mono <= w_mono;
      r_x    <= i_x;
      r_y    <= i_y;
      r_rnd  <= i_r;
    end
  end

  assign {w_j, w_i, w_h, w_g, w_f, w_e, w_d, w_c, w_b, w_a} = r_mono;
  assign w_rm = (REFRESH_EN != 0) ? r_rnd : 4'h0;

  // Refresh XORs the same mask into both shares, so s^t is unchanged.
  assign o_s = w_rm ^ {r_y[2] ^ w_d ^ w_c ^ w_e ^ w_f ^ w_g ^ w_h ^ w_i,
                       w_h ^ w_j ^ w_a ^ r_x,
                       w_g ^ w_j ^ w_b ^ w_d,
                       w_g ^ w_d ^ w_c ^ r_y[1]};
  assign o_t = w_rm ^ {r_x ^ w_a ^ w_b ^ w_c ^ w_e ^ w_g ^ w_i ^ w_j,
                       w_g ^ w_h ^ w_b ^ w_d,
                       w_g ^ w_b ^ w_d,
                       w_h ^ w_i ^ w_d ^ r_y[2]};
endmodule

module glm_domain_pipe #(
  parameter int NIBBLES    = 16,
  parameter int PIPE       = 2,
  parameter int REFRESH_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIBBLES-1:0]   x,
  input  logic [3*NIBBLES-1:0] y,
  input  logic [4*NIBBLES-1:0] r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] s,
  output logic [4*NIBBLES-1:0] t
);
  logic                     r_v1;
  logic                     w_adv1;
  logic [NIBBLES-1:0][3:0]  w_s1, w_t1;

  assign w_adv1 = in_valid & in_ready;

  for (genvar k = 0; k < NIBBLES; k++) begin : g_lane
    glm_domain_lane #(.REFRESH_EN(REFRESH_EN)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_ld  (w_adv1),
      .i_x   (x[k]),
      .i_y   (y[3*k +: 3]),
      .i_r   (r[4*k +: 4]),
      .o_s   (w_s1[k]),
      .o_t   (w_t1[k])
    );
  end

  if (PIPE == 2) begin : g_p2
    logic                 r_v2, w_adv2;
    logic [4*NIBBLES-1:0] r_s, r_t;

    // Stage 2 takes stage 1 when empty or draining; stage 1 refills in the
    // same cycle it hands off, so a full pipe streams one beat per cycle.
    assign w_adv2   = r_v1 & (~r_v2 | out_ready);
    assign in_ready = ~r_v1 | w_adv2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
        r_s  <= '0;
        r_t  <= '0;
      end else begin
        if (w_adv1)      r_v1 <= 1'b1;
        else if (w_adv2) r_v1 <= 1'b0;
        if (w_adv2)         r_v2 <= 1'b1;
        else if (out_ready) r_v2 <= 1'b0;
        if (w_adv2) begin
          r_s <= w_s1;
          r_t <= w_t1;
        end
      end
    end

    assign out_valid = r_v2;
    assign s         = r_s;
    assign t         = r_t;
  end else begin : g_p1
    assign in_ready = ~r_v1 | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_v1 <= 1'b0;
      else if (w_adv1)    r_v1 <= 1'b1;
      else if (out_ready) r_v1 <= 1'b0;
    end

    assign out_valid = r_v1;
    assign s         = w_s1;
    assign t         = w_t1;
  end
endmodule

// File: doc/glm_domain_pipe.md
Name: glm_domain_pipe

Overview:
- Parametrised, pipelined successor of the single-nibble GLM cubic domain function used in the first-order masked PRINCE S-box.
- Evaluates the eight domain output functions (s0..s3, t0..t3) for NIBBLES parallel nibbles per domain instance.
- Registers all nonlinear monomials before XOR compression, which stops glitch propagation across the AND layer.
- Adds a fresh-mask refresh and a valid/ready handshake so the block sits directly in the S-box layer of the round datapath.

Parameters:
- NIBBLES, 16, number of parallel nibble lanes (1..16).
- PIPE, 2, pipeline depth. 2 = monomial register plus output register. 1 = monomial register only, with outputs driven combinationally from it.
- REFRESH_EN, 1, 1 = XOR the fresh mask r into the outputs. 0 = r is ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- x  in  NIBBLES  per-lane x share bit; lane k = x[k].
- y  in  3*NIBBLES  per-lane y share bits; lane k = y[3k+2:3k], mapped as {y2,y1,y0}.
- r  in  4*NIBBLES  fresh randomness; lane k = r[4k+3:4k].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- s  out  4*NIBBLES  lane k = {s3,s2,s1,s0}.
- t  out  4*NIBBLES  lane k = {t3,t2,t1,t0}.

Behaviour:
- Per-lane monomials: a=x&y0, b=x&y1, c=x&y2, d=y0&y1, e=y0&y2, f=y1&y2, g=x&y0&y1, h=x&y0&y2, i=x&y1&y2, j=y0&y1&y2.
- Stage 1 registers (load on input handshake): the 10 monomials, x, y0, y1, y2, and r, per lane.
- Compression, computed from stage-1 registers only:
  - s0=g^d^c^y1
  - s1=g^j^b^d
  - s2=h^j^a^x
  - s3=y2^d^c^e^f^g^h^i
  - t0=h^i^d^y2
  - t1=g^b^d
  - t2=g^h^b^d
  - t3=x^a^b^c^e^g^i^j
- Refresh (REFRESH_EN=1): final s[4k+n] = s_n ^ r_k[n] and t[4k+n] = t_n ^ r_k[n]. This keeps s^t invariant.
- PIPE=2:
  - Stage 2 registers s and t, loaded when stage 1 is valid and stage 2 is free or draining.
  - adv2 = v1 & (!v2 | out_ready).
  - in_ready = !v1 | adv2.
  - out_valid = v2.
  - Latency: 2 cycles from the accepted beat to out_valid.
  - Throughput: 1 beat/cycle with out_ready held high.
- PIPE=1:
  - out_valid = v1.
  - in_ready = !v1 | out_ready.
  - Latency: 1 cycle.
- Stall: with out_valid=1 and out_ready=0, s and t hold stable and no register loads except into an empty stage (bubble collapse).
- Simultaneous accept and drain on a full stage: the new beat replaces the old one in the same cycle, with no loss or duplication.
- Registers never load without a handshake. Data registers hold their values while idle.
- Reset (async assert, synchronous-edge release): v1=v2=0, all data registers=0, out_valid=0, s=t=0, in_ready=1 from the first cycle after release.
- Reset mid-operation: beats in flight are dropped with no partial output.
- No combinational path from in_* to out_*. in_ready depends only on registered state and out_ready.

Test Plan:
- Reset, NIBBLES=16, PIPE=2: assert rst_n=0 mid-stream -> out_valid=0, s=t=0 immediately; after release in_ready=1 and no stale beat appears.
- r=0, lane 0 drives x=1, y=3'b111 -> s=4'b0000, t=4'b0010 exactly 2 cycles after accept. Then x=1, y=3'b000 -> s=4'b0100, t=4'b1000. Then x=0, y=3'b100 -> s=4'b1000, t=4'b0001.
- Refresh: same first vector with r=4'b1011 -> s=4'b1011, t=4'b1001; s^t=4'b0010. With REFRESH_EN=0 -> unrefreshed values.
- Backpressure: stream 6 beats, out_ready low for cycles 3-5 -> in_ready drops after both stages fill, outputs stay stable, all 6 beats emerge in order with none lost or duplicated.
- Full throughput: out_ready=1, continuous in_valid, random x/y/r over 1000 beats -> one output per cycle, all matching the reference model on all 16 lanes.
- PIPE=1, NIBBLES=1: exhaustive 16 x/y combinations -> 1-cycle latency, all match the equations.
